// File: rtl/mem_bist_pkg.sv
// Shared definitions for the memory BIST engine: FSM encoding and the
// address-derived test pattern.
package mem_bist_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WRITE = 3'd1;
   localparam logic [2:0] ST_READ  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   // Pass 0 uses addr^seed, pass 1 its complement; callers truncate to DATA_W.
   function automatic logic [31:0] bist_pat(input logic [31:0] addr,
                                            input logic [31:0] seed,
                                            input logic        pass);
      logic [31:0] w_p;
      w_p = addr ^ seed;
      return pass ? ~w_p : w_p;
   endfunction

endpackage

// File: rtl/mem_bist_cmp.sv
// Read-data checker: delays each read's expected word/address by READ_LAT
// cycles, compares against memory output and accumulates the results.
module mem_bist_cmp #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int READ_LAT = 1,
   parameter int ERR_W    = 16
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              i_clr,
   input  logic              i_req,
   input  logic [DATA_W-1:0] i_exp,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_rdata,
   output logic [ERR_W-1:0]  o_err_cnt,
   output logic [ADDR_W-1:0] o_first_addr
);

   logic [READ_LAT-1:0]             r_vld;
   logic [READ_LAT-1:0][DATA_W-1:0] r_exp;
   logic [READ_LAT-1:0][ADDR_W-1:0] r_addr;
   logic [ERR_W-1:0]                r_err;
   logic [ADDR_W-1:0]               r_first;
   logic                            w_miss;

   assign w_miss       = r_vld[READ_LAT-1] && (i_rdata != r_exp[READ_LAT-1]);
   assign o_err_cnt    = r_err;
   assign o_first_addr = r_first;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_vld   <= '0;
         r_exp   <= '0;
         r_addr  <= '0;
         r_err   <= '0;
         r_first <= '0;
      end else if (i_clr) begin
         r_vld   <= '0;
         r_exp   <= '0;
         r_addr  <= '0;
         r_err   <= '0;
         r_first <= '0;
      end else begin
         for (int i = READ_LAT - 1; i > 0; i--) begin
            r_vld[i]  <= r_vld[i-1];
            r_exp[i]  <= r_exp[i-1];
            r_addr[i] <= r_addr[i-1];
         end
         r_vld[0]  <= i_req;
         r_exp[0]  <= i_exp;
         r_addr[0] <= i_addr;
         if (w_miss) begin
            if (r_err != '1)
               r_err <= r_err + 1'b1;
            // A saturated count never returns to zero, so zero means "no error yet".
            if (r_err == '0)
               r_first <= r_addr[READ_LAT-1];
         end
      end
   end

endmodule

// File: rtl/mem_bist_ctrl.sv
// Two-pass march BIST sequencer: writes P(a) then reads back, repeats with
// ~P(a); all memory port signals come straight from registers.
module mem_bist_ctrl
   import mem_bist_pkg::*;
#(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int DEPTH    = 1024,
   parameter int READ_LAT = 1,
   parameter int ERR_W    = 16
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              Start,
   input  logic [DATA_W-1:0] Seed,
   output logic              Busy,
   output logic              Done,
   output logic              Pass,
   output logic [ERR_W-1:0]  ErrCount,
   output logic [ADDR_W-1:0] FirstErrAddr,
   output logic [ADDR_W-1:0] Mem_Address,
   output logic [DATA_W-1:0] Mem_DataIn,
   output logic              Mem_WriteEna,
   output logic              Mem_ReadEna,
   input  logic [DATA_W-1:0] Mem_DataOut
);

   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
   localparam logic [2:0]        LAST_DRAIN = 3'(READ_LAT - 1);

   logic [2:0]        r_state;
   logic              r_pass;
   logic [ADDR_W-1:0] r_addr;
   logic [2:0]        r_drain;
   logic [DATA_W-1:0] r_seed;
   logic [DATA_W-1:0] r_dat;
   logic [DATA_W-1:0] r_exp;
   logic              r_wr;
   logic              r_rd;
   logic              w_start;
   logic [ADDR_W-1:0] w_next;

   assign w_start = Start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_next  = r_addr + 1'b1;

   assign Busy         = (r_state == ST_WRITE) || (r_state == ST_READ) || (r_state == ST_DRAIN);
   assign Done         = (r_state == ST_DONE);
   assign Pass         = Done && (ErrCount == '0);
   assign Mem_Address  = r_addr;
   assign Mem_DataIn   = r_dat;
   assign Mem_WriteEna = r_wr;
   assign Mem_ReadEna  = r_rd;

   // Each state presents the *next* access, so the port is registered and
   // the first write appears in the cycle right after Start is sampled.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_state <= ST_IDLE;
         r_pass  <= 1'b0;
         r_addr  <= '0;
         r_drain <= '0;
         r_seed  <= '0;
         r_dat   <= '0;
         r_exp   <= '0;
         r_wr    <= 1'b0;
         r_rd    <= 1'b0;
      end else begin
         r_wr  <= 1'b0;
         r_rd  <= 1'b0;
         r_dat <= '0;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_start) begin
                  r_state <= ST_WRITE;
                  r_seed  <= Seed;
                  r_pass  <= 1'b0;
                  r_addr  <= '0;
                  r_wr    <= 1'b1;
                  r_dat   <= DATA_W'(bist_pat(32'd0, 32'(Seed), 1'b0));
               end
            end
            ST_WRITE: begin
               if (r_addr == LAST_ADDR) begin
                  r_state <= ST_READ;
                  r_addr  <= '0;
                  r_rd    <= 1'b1;
                  r_exp   <= DATA_W'(bist_pat(32'd0, 32'(r_seed), r_pass));
               end else begin
                  r_addr  <= w_next;
                  r_wr    <= 1'b1;
                  r_dat   <= DATA_W'(bist_pat(32'(w_next), 32'(r_seed), r_pass));
               end
            end
            ST_READ: begin
               if (r_addr == LAST_ADDR) begin
                  r_state <= ST_DRAIN;
                  r_drain <= '0;
               end else begin
                  r_addr  <= w_next;
                  r_rd    <= 1'b1;
                  r_exp   <= DATA_W'(bist_pat(32'(w_next), 32'(r_seed), r_pass));
               end
            end
            ST_DRAIN: begin
               if (r_drain == LAST_DRAIN) begin
                  if (!r_pass) begin
                     r_state <= ST_WRITE;
                     r_pass  <= 1'b1;
                     r_addr  <= '0;
                     r_wr    <= 1'b1;
                     r_dat   <= DATA_W'(bist_pat(32'd0, 32'(r_seed), 1'b1));
                  end else begin
                     r_state <= ST_DONE;
                  end
               end else begin
                  r_drain <= r_drain + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   mem_bist_cmp #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .READ_LAT (READ_LAT),
      .ERR_W    (ERR_W)
   ) u_cmp (
      .CLK          (CLK),
      .Reset        (Reset),
      .i_clr        (w_start),
      .i_req        (r_rd),
      .i_exp        (r_exp),
      .i_addr       (r_addr),
      .i_rdata      (Mem_DataOut),
      .o_err_cnt    (ErrCount),
      .o_first_addr (FirstErrAddr)
   );

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl with a one-cycle memory model and a
// scoreboard of expected memory-port accesses.
module tb_mem_bist_ctrl;

   localparam int AW = 16, DW = 16, DEPTH = 16, RL = 1, EW = 4;
   localparam int PASS_CYC = 2 * DEPTH + RL;

   typedef struct packed {
      logic [31:0] cyc;
      logic        we;
      logic        re;
      logic [15:0] addr;
      logic [15:0] data;
   } txn_t;

   logic          CLK = 1'b0;
   logic          Reset, Start;
   logic [DW-1:0] Seed;
   logic          Busy, Done, Pass;
   logic [EW-1:0] ErrCount;
   logic [AW-1:0] FirstErrAddr, Mem_Address;
   logic [DW-1:0] Mem_DataIn, Mem_DataOut;
   logic          Mem_WriteEna, Mem_ReadEna;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   mode  = 0;
   txn_t q[$];
   logic [15:0] mem [0:15];

   mem_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .READ_LAT(RL), .ERR_W(EW)) dut (
      .CLK(CLK), .Reset(Reset), .Start(Start), .Seed(Seed),
      .Busy(Busy), .Done(Done), .Pass(Pass), .ErrCount(ErrCount), .FirstErrAddr(FirstErrAddr),
      .Mem_Address(Mem_Address), .Mem_DataIn(Mem_DataIn), .Mem_WriteEna(Mem_WriteEna),
      .Mem_ReadEna(Mem_ReadEna), .Mem_DataOut(Mem_DataOut)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc = cyc + 1;

   function automatic logic [15:0] fault(input logic [3:0] a, input logic [15:0] d);
      case (mode)
         1:       return (a == 4'd5) ? (d & ~16'h0008) : d;
         2:       return (a == 4'd2) ? 16'hFFFF : d;
         3:       return 16'h0000;
         default: return d;
      endcase
   endfunction

   function automatic logic [15:0] pat(input int a, input logic [15:0] s, input bit p);
      logic [15:0] v;
      v = 16'(a) ^ s;
      return p ? ~v : v;
   endfunction

   always @(posedge CLK) begin
      if (Mem_WriteEna) mem[Mem_Address[3:0]] <= Mem_DataIn;
      if (Mem_ReadEna)  Mem_DataOut <= fault(Mem_Address[3:0], mem[Mem_Address[3:0]]);
   end

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_run(input int k, input logic [15:0] s);
      txn_t t;
      for (int p = 0; p < 2; p++)
         for (int a = 0; a < DEPTH; a++) begin
            t = '{cyc: 32'(k + p*PASS_CYC + a), we: 1'b1, re: 1'b0, addr: 16'(a), data: pat(a, s, p[0])};
            q.push_back(t);
         end
      q.sort() with (item.cyc);
      for (int p = 0; p < 2; p++)
         for (int a = 0; a < DEPTH; a++) begin
            t = '{cyc: 32'(k + p*PASS_CYC + DEPTH + a), we: 1'b0, re: 1'b1, addr: 16'(a), data: 16'h0};
            q.push_back(t);
         end
      q.sort() with (item.cyc);
   endtask

   always @(negedge CLK) begin
      txn_t o, e;
      if (!Reset) begin
         if (Mem_WriteEna || Mem_ReadEna) begin
            chk("we_re_exclusive", 96'(Mem_WriteEna & Mem_ReadEna), 96'd0);
            o = '{cyc: 32'(cyc), we: Mem_WriteEna, re: Mem_ReadEna, addr: Mem_Address, data: Mem_DataIn};
            if (q.size() == 0) chk("unexpected_access", 96'(o), 96'd0);
            else begin
               e = q.pop_front();
               chk("mem_txn", 96'(o), 96'(e));
            end
         end else begin
            chk("din_zero_idle", 96'(Mem_DataIn), 96'd0);
         end
      end
   end

   task automatic run(input logic [15:0] s, input int m, input logic [EW-1:0] e_err,
                      input logic [AW-1:0] e_first, input bit repulse);
      int k;
      mode  = m;
      k     = cyc + 1;
      push_run(k, s);
      Seed  = s;
      Start = 1'b1;
      @(negedge CLK);
      Start = 1'b0;
      Seed  = 16'($urandom);
      chk("busy_at_k",   96'(Busy), 96'd1);
      chk("done_at_k",   96'(Done), 96'd0);
      chk("err_clr_k",   96'(ErrCount), 96'd0);
      chk("first_clr_k", 96'(FirstErrAddr), 96'd0);
      for (int i = 1; i <= 2*PASS_CYC - 1; i++) begin
         @(negedge CLK);
         Start = repulse && ((cyc == k + 9) || (cyc == k + 39));
      end
      Start = 1'b0;
      chk("done_early", 96'(Done), 96'd0);
      chk("busy_late",  96'(Busy), 96'd1);
      @(negedge CLK);
      chk("done",      96'(Done), 96'd1);
      chk("busy_off",  96'(Busy), 96'd0);
      chk("pass",      96'(Pass), 96'(e_err == '0));
      chk("err_count", 96'(ErrCount), 96'(e_err));
      chk("first_err", 96'(FirstErrAddr), 96'(e_first));
      chk("sb_empty",  96'(q.size()), 96'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 96'(Busy), 96'd0);
      chk({tag, "_done"}, 96'(Done), 96'd0);
      chk({tag, "_pass"}, 96'(Pass), 96'd0);
      chk({tag, "_err"},  96'(ErrCount), 96'd0);
      chk({tag, "_first"}, 96'(FirstErrAddr), 96'd0);
      chk({tag, "_addr"}, 96'(Mem_Address), 96'd0);
      chk({tag, "_din"},  96'(Mem_DataIn), 96'd0);
      chk({tag, "_we"},   96'(Mem_WriteEna), 96'd0);
      chk({tag, "_re"},   96'(Mem_ReadEna), 96'd0);
   endtask

   initial begin
      int k;
      Reset = 1'b1; Start = 1'b0; Seed = '0; Mem_DataOut = '0;
      repeat (3) @(negedge CLK);
      chk_all_zero("reset");
      Reset = 1'b0;
      @(negedge CLK);

      run(16'h00FF, 0, 4'd0, 16'd0, 1'b0);
      run(16'h0000, 1, 4'd1, 16'd5, 1'b0);
      repeat (3) @(negedge CLK);
      chk("done_held", 96'(Done), 96'd1);
      run(16'h0000, 2, 4'd2, 16'd2, 1'b1);
      run(16'h3C3C, 0, 4'd0, 16'd0, 1'b0);
      run(16'h1234, 3, 4'd15, 16'd0, 1'b0);

      mode  = 0;
      k     = cyc + 1;
      push_run(k, 16'hA5A5);
      Seed  = 16'hA5A5;
      Start = 1'b1;
      @(negedge CLK);
      Start = 1'b0;
      repeat (20) @(negedge CLK);
      chk("rd_before_reset", 96'(Mem_ReadEna), 96'd1);
      #2 Reset = 1'b1;
      #1 chk_all_zero("async_reset");
      q.delete();
      @(negedge CLK);
      Reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         chk("en_after_reset", 96'({Mem_WriteEna, Mem_ReadEna}), 96'd0);
      end
      run(16'hA5A5, 0, 4'd0, 16'd0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
